// File: rtl/probe_msg_tx.sv
// Announces the probe menu state as a short ASCII line over a valid/ready text sink,
// and tracks the sink's cursor column as characters are accepted.
module probe_msg_tx #(
    parameter logic EOL_LF = 1'b1
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [2:0] PRB_ST,
    input  logic       CLR_XPOS,
    input  logic       TX_READY,
    output logic [7:0] TX_DATA,
    output logic       TX_VALID,
    output logic [6:0] XPOS,
    output logic       BUSY,
    output logic       MSG_DONE
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_CR,
        S_LF,
        S_DONE
    } state_t;

    state_t     r_state;
    logic [2:0] r_prbQ;
    logic [2:0] r_ann;
    logic [2:0] r_msg;
    logic [2:0] r_idx;
    logic [6:0] r_xpos;
    logic [7:0] r_txData;
    logic       r_txValid;
    logic       r_busy;
    logic       r_msgDone;

    state_t     w_stateNext;
    logic [2:0] w_annNext;
    logic [2:0] w_msgNext;
    logic [2:0] w_idxNext;
    logic [6:0] w_xposNext;
    logic [7:0] w_txDataNext;
    logic       w_txValidNext;
    logic       w_xfer;

    function automatic logic [7:0] romChar(input logic [2:0] msg, input logic [2:0] idx);
        logic [39:0] text;
        logic [7:0]  ch;
        case (msg)
            3'd1:    text = 40'h4D4F44453F;
            3'd2:    text = 40'h52554E2041;
            3'd3:    text = 40'h53454C2042;
            3'd4:    text = 40'h53454C2043;
            default: text = 40'h0;
        endcase
        case (idx)
            3'd0:    ch = text[39:32];
            3'd1:    ch = text[31:24];
            3'd2:    ch = text[23:16];
            3'd3:    ch = text[15:8];
            3'd4:    ch = text[7:0];
            default: ch = 8'h00;
        endcase
        return ch;
    endfunction

    assign w_xfer = r_txValid & TX_READY;

    always_comb begin
        w_stateNext = r_state;
        w_annNext   = r_ann;
        w_msgNext   = r_msg;
        w_idxNext   = r_idx;
        w_xposNext  = r_xpos;
        case (r_state)
            // Only the latest registered probe state is compared, so states that
            // came and went during a message are never announced.
            S_IDLE: begin
                if (r_prbQ != r_ann) begin
                    w_annNext = r_prbQ;
                    if (r_prbQ >= 3'd1 && r_prbQ <= 3'd4) begin
                        w_msgNext   = r_prbQ;
                        w_idxNext   = 3'd0;
                        w_stateNext = S_SEND;
                    end
                end
            end
            S_SEND: begin
                if (w_xfer) begin
                    if (r_xpos != 7'd127) begin
                        w_xposNext = r_xpos + 7'd1;
                    end
                    if (r_idx == 3'd4) begin
                        w_stateNext = S_CR;
                    end else begin
                        w_idxNext = r_idx + 3'd1;
                    end
                end
            end
            S_CR: begin
                if (w_xfer) begin
                    w_xposNext  = 7'd0;
                    w_stateNext = EOL_LF ? S_LF : S_DONE;
                end
            end
            S_LF: begin
                if (w_xfer) begin
                    w_stateNext = S_DONE;
                end
            end
            S_DONE:  w_stateNext = S_IDLE;
            default: w_stateNext = S_IDLE;
        endcase
        if (CLR_XPOS) begin
            w_xposNext = 7'd0;
        end
    end

    // Character outputs are decoded from the next state so they can be registered
    // and stay stable while the sink stalls.
    always_comb begin
        w_txValidNext = 1'b0;
        w_txDataNext  = 8'h00;
        case (w_stateNext)
            S_SEND: begin
                w_txValidNext = 1'b1;
                w_txDataNext  = romChar(w_msgNext, w_idxNext);
            end
            S_CR: begin
                w_txValidNext = 1'b1;
                w_txDataNext  = 8'h0D;
            end
            S_LF: begin
                w_txValidNext = 1'b1;
                w_txDataNext  = 8'h0A;
            end
            default: begin
                w_txValidNext = 1'b0;
                w_txDataNext  = 8'h00;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state   <= S_IDLE;
            r_prbQ    <= 3'd0;
            r_ann     <= 3'd0;
            r_msg     <= 3'd0;
            r_idx     <= 3'd0;
            r_xpos    <= 7'd0;
            r_txData  <= 8'h00;
            r_txValid <= 1'b0;
            r_busy    <= 1'b0;
            r_msgDone <= 1'b0;
        end else begin
            r_state   <= w_stateNext;
            r_prbQ    <= PRB_ST;
            r_ann     <= w_annNext;
            r_msg     <= w_msgNext;
            r_idx     <= w_idxNext;
            r_xpos    <= w_xposNext;
            r_txData  <= w_txDataNext;
            r_txValid <= w_txValidNext;
            r_busy    <= (w_stateNext != S_IDLE);
            r_msgDone <= (w_stateNext == S_DONE);
        end
    end

    assign TX_DATA  = r_txData;
    assign TX_VALID = r_txValid;
    assign XPOS     = r_xpos;
    assign BUSY     = r_busy;
    assign MSG_DONE = r_msgDone;

endmodule

// File: tb/tb_probe_msg_tx.sv
// Bench for probe_msg_tx: a CR-only and a CR+LF instance share all inputs and are
// compared every cycle against a byte-string model of the announced text.
module tb_probe_msg_tx;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic [2:0] PRB_ST;
    logic       CLR_XPOS;
    logic       TX_READY;

    logic [7:0] txData  [2];
    logic       txValid [2];
    logic [6:0] xpos    [2];
    logic       busy    [2];
    logic       msgDone [2];

    int testsRun    = 0;
    int testsFailed = 0;
    int cyc         = 0;
    bit checkEn     = 1'b0;

    // Model state: whether a line is being streamed, which text, and the byte position in it.
    bit         mAct  [2] = '{1'b0, 1'b0};
    bit         mDone [2] = '{1'b0, 1'b0};
    int         mPos  [2] = '{0, 0};
    logic [2:0] mMsg  [2] = '{3'd0, 3'd0};
    logic [2:0] mAnn  [2] = '{3'd0, 3'd0};
    int         mXpos [2] = '{0, 0};
    logic [2:0] mPrb      = 3'd0;

    logic [7:0] log0 [$];
    logic [7:0] log1 [$];
    bit         seenLf0  = 1'b0;
    int         doneCnt1 = 0;
    int         riseCyc1 = -1;
    logic       prevValid1 = 1'b0;

    probe_msg_tx #(.EOL_LF(1'b0)) dutCr (
        .CLK(CLK), .RST_N(RST_N), .PRB_ST(PRB_ST), .CLR_XPOS(CLR_XPOS), .TX_READY(TX_READY),
        .TX_DATA(txData[0]), .TX_VALID(txValid[0]), .XPOS(xpos[0]), .BUSY(busy[0]),
        .MSG_DONE(msgDone[0])
    );

    probe_msg_tx #(.EOL_LF(1'b1)) dutCrLf (
        .CLK(CLK), .RST_N(RST_N), .PRB_ST(PRB_ST), .CLR_XPOS(CLR_XPOS), .TX_READY(TX_READY),
        .TX_DATA(txData[1]), .TX_VALID(txValid[1]), .XPOS(xpos[1]), .BUSY(busy[1]),
        .MSG_DONE(msgDone[1])
    );

    always #5 CLK = ~CLK;

    function automatic logic [7:0] msgByte(input logic [2:0] m, input int p);
        logic [39:0] text;
        case (m)
            3'd1:    text = "MODE?";
            3'd2:    text = "RUN A";
            3'd3:    text = "SEL B";
            3'd4:    text = "SEL C";
            default: text = 40'h0;
        endcase
        if (p < 5) return text[8*(4-p) +: 8];
        if (p == 5) return 8'h0D;
        return 8'h0A;
    endfunction

    function automatic int lineLen(input int k);
        return (k == 1) ? 7 : 6;
    endfunction

    function automatic logic [127:0] packLog(input int k);
        logic [111:0] v;
        int n;
        v = '0;
        if (k == 0) begin
            foreach (log0[i]) v = {v[103:0], log0[i]};
            n = log0.size();
        end else begin
            foreach (log1[i]) v = {v[103:0], log1[i]};
            n = log1.size();
        end
        return {16'(n), v};
    endfunction

    function automatic logic [127:0] expLog(input int n, input logic [111:0] bytes);
        return {16'(n), bytes};
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] prb, input logic rdy, input logic clr,
                                 input logic rstn);
        @(posedge CLK);
        #1;
        PRB_ST   = prb;
        TX_READY = rdy;
        CLR_XPOS = clr;
        RST_N    = rstn;
    endtask

    // Reference: after a change of the registered probe state is seen while idle,
    // the line's bytes are handed out one per accepted transfer, then one done cycle.
    always @(posedge CLK) begin
        cyc = cyc + 1;
        for (int k = 0; k < 2; k++) begin
            if (!RST_N) begin
                mAct[k]  = 1'b0;
                mDone[k] = 1'b0;
                mPos[k]  = 0;
                mAnn[k]  = 3'd0;
                mXpos[k] = 0;
            end else begin
                if (mAct[k]) begin
                    if (TX_READY) begin
                        logic [7:0] b;
                        b = msgByte(mMsg[k], mPos[k]);
                        if (b == 8'h0D) mXpos[k] = 0;
                        else if (b != 8'h0A && mXpos[k] < 127) mXpos[k] = mXpos[k] + 1;
                        mPos[k] = mPos[k] + 1;
                        if (mPos[k] == lineLen(k)) begin
                            mAct[k]  = 1'b0;
                            mDone[k] = 1'b1;
                        end
                    end
                end else if (mDone[k]) begin
                    mDone[k] = 1'b0;
                end else if (mPrb != mAnn[k]) begin
                    mAnn[k] = mPrb;
                    if (mPrb >= 3'd1 && mPrb <= 3'd4) begin
                        mAct[k] = 1'b1;
                        mMsg[k] = mPrb;
                        mPos[k] = 0;
                    end
                end
                if (CLR_XPOS) mXpos[k] = 0;
            end
        end
        mPrb = RST_N ? PRB_ST : 3'd0;
    end

    always @(negedge CLK) begin
        if (checkEn) begin
            for (int k = 0; k < 2; k++) begin
                checkOutput($sformatf("valid%0d", k), 128'(txValid[k]), 128'(mAct[k]));
                checkOutput($sformatf("data%0d", k), 128'(txData[k]),
                            128'(mAct[k] ? msgByte(mMsg[k], mPos[k]) : 8'h00));
                checkOutput($sformatf("xpos%0d", k), 128'(xpos[k]), 128'(mXpos[k]));
                checkOutput($sformatf("busy%0d", k), 128'(busy[k]), 128'(mAct[k] | mDone[k]));
                checkOutput($sformatf("msgDone%0d", k), 128'(msgDone[k]), 128'(mDone[k]));
            end
        end
        if (RST_N === 1'b1 && TX_READY === 1'b1) begin
            if (txValid[0] === 1'b1) begin
                log0.push_back(txData[0]);
                if (txData[0] == 8'h0A) seenLf0 = 1'b1;
            end
            if (txValid[1] === 1'b1) log1.push_back(txData[1]);
        end
        if (msgDone[1] === 1'b1) doneCnt1++;
        if (txValid[1] === 1'b1 && prevValid1 !== 1'b1) riseCyc1 = cyc;
        prevValid1 = txValid[1];
    end

    initial begin
        int chgCyc;
        int rstCyc;
        bit reached;
        RST_N    = 1'b0;
        PRB_ST   = 3'd0;
        CLR_XPOS = 1'b0;
        TX_READY = 1'b0;
        applyStimulus(3'd0, 1'b0, 1'b0, 1'b0);
        applyStimulus(3'd0, 1'b0, 1'b0, 1'b0);
        checkEn = 1'b1;
        applyStimulus(3'd0, 1'b1, 1'b0, 1'b1);
        @(negedge CLK);
        #1;
        checkOutput("resetValid", 128'(txValid[1]), 128'(1'b0));
        checkOutput("resetData", 128'(txData[1]), 128'(8'h00));
        checkOutput("resetXpos", 128'(xpos[1]), 128'(7'd0));
        checkOutput("resetBusy", 128'(busy[1]), 128'(1'b0));

        // 0 -> 1 with the sink always ready
        log0.delete();
        log1.delete();
        doneCnt1 = 0;
        applyStimulus(3'd1, 1'b1, 1'b0, 1'b1);
        chgCyc = cyc;
        repeat (12) applyStimulus(3'd1, 1'b1, 1'b0, 1'b1);
        checkOutput("firstValidLatency", 128'(riseCyc1), 128'(chgCyc + 2));
        checkOutput("modeLineCrLf", packLog(1), expLog(7, {"MODE?", 8'h0D, 8'h0A}));
        checkOutput("modeLineCr", packLog(0), expLog(6, {"MODE?", 8'h0D}));
        checkOutput("modeDonePulses", 128'(doneCnt1), 128'(1));
        checkOutput("modeXposAfter", 128'(xpos[1]), 128'(7'd0));

        // 1 -> 2 with the sink toggling ready every cycle
        log1.delete();
        for (int i = 0; i < 24; i++) applyStimulus(3'd2, 1'(i % 2), 1'b0, 1'b1);
        repeat (6) applyStimulus(3'd2, 1'b1, 1'b0, 1'b1);
        checkOutput("runLineToggle", packLog(1), expLog(7, {"RUN A", 8'h0D, 8'h0A}));

        // 1 -> 3 -> 2 inside one message: only the last state follows
        log1.delete();
        repeat (3) applyStimulus(3'd1, 1'b1, 1'b0, 1'b1);
        applyStimulus(3'd3, 1'b1, 1'b0, 1'b1);
        repeat (30) applyStimulus(3'd2, 1'b1, 1'b0, 1'b1);
        checkOutput("skipIntermediate", packLog(1),
                    expLog(14, {"MODE?", 8'h0D, 8'h0A, "RUN A", 8'h0D, 8'h0A}));

        // 4 -> 0 -> 4: the silent state still re-arms the announcement
        log1.delete();
        repeat (14) applyStimulus(3'd4, 1'b1, 1'b0, 1'b1);
        repeat (5) applyStimulus(3'd0, 1'b1, 1'b0, 1'b1);
        repeat (14) applyStimulus(3'd4, 1'b1, 1'b0, 1'b1);
        checkOutput("selCTwice", packLog(1),
                    expLog(14, {"SEL C", 8'h0D, 8'h0A, "SEL C", 8'h0D, 8'h0A}));

        // Reset right after the 2nd char of "SEL B", then restart
        log1.delete();
        reached = 1'b0;
        for (int i = 0; i < 20 && !reached; i++) begin
            applyStimulus(3'd3, 1'b1, 1'b0, 1'b1);
            @(negedge CLK);
            #1;
            if (log1.size() >= 2) reached = 1'b1;
        end
        checkOutput("waitSecondChar", 128'(reached), 128'(1'b1));
        applyStimulus(3'd3, 1'b1, 1'b0, 1'b0);
        applyStimulus(3'd3, 1'b1, 1'b0, 1'b1);
        rstCyc = cyc;
        @(negedge CLK);
        #1;
        checkOutput("midResetValid", 128'(txValid[1]), 128'(1'b0));
        checkOutput("midResetBusy", 128'(busy[1]), 128'(1'b0));
        repeat (14) applyStimulus(3'd3, 1'b1, 1'b0, 1'b1);
        checkOutput("restartLatency", 128'(riseCyc1), 128'(rstCyc + 2));
        checkOutput("selBRestart", packLog(1),
                    expLog(9, {8'h53, 8'h45, "SEL B", 8'h0D, 8'h0A}));

        // Cursor clear coinciding with the 3rd printable transfer of "MODE?"
        log1.delete();
        reached = 1'b0;
        for (int i = 0; i < 20 && !reached; i++) begin
            applyStimulus(3'd1, 1'b1, 1'b0, 1'b1);
            @(negedge CLK);
            #1;
            if (log1.size() >= 2) reached = 1'b1;
        end
        checkOutput("waitClrPoint", 128'(reached), 128'(1'b1));
        applyStimulus(3'd1, 1'b1, 1'b1, 1'b1);
        applyStimulus(3'd1, 1'b1, 1'b0, 1'b1);
        @(negedge CLK);
        #1;
        checkOutput("clrXposZero", 128'(xpos[1]), 128'(7'd0));
        applyStimulus(3'd1, 1'b1, 1'b0, 1'b1);
        @(negedge CLK);
        #1;
        checkOutput("clrXposNext", 128'(xpos[1]), 128'(7'd1));
        repeat (10) applyStimulus(3'd1, 1'b1, 1'b0, 1'b1);

        // Randomized probe states, sink stalls, cursor clears and occasional resets
        for (int s = 0; s < 300; s++) begin
            logic [2:0] prb;
            int len;
            prb = 3'($urandom_range(0, 7));
            len = $urandom_range(1, 24);
            for (int c = 0; c < len; c++) begin
                applyStimulus(prb, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 19) == 0),
                              1'($urandom_range(0, 299) != 0));
            end
        end
        repeat (20) applyStimulus(3'd0, 1'b1, 1'b0, 1'b1);
        checkOutput("crOnlyNeverLf", 128'(seenLf0), 128'(1'b0));

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
